// File: rtl/pc_unit_if.sv
// Fetch-stage control bundle between the core and pc_unit.
// The core drives the redirect/trap requests; pc_unit returns the fetch PC and status.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             npc_valid;
    logic [WIDTH-1:0] npc;
    logic             int_req;
    logic             exc_req;
    logic             eret;
    logic [WIDTH-1:0] epc_in;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             pc_exp;
    logic [WIDTH-1:0] bad_pc;
    logic             redirect;
    logic             in_handler;

    modport master (
        output stall, npc_valid, npc, int_req, exc_req, eret, epc_in,
        input  pc, pc_plus4, pc_exp, bad_pc, redirect, in_handler
    );

    modport slave (
        input  stall, npc_valid, npc, int_req, exc_req, eret, epc_in,
        output pc, pc_plus4, pc_exp, bad_pc, redirect, in_handler
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC, picks the next PC (trap, ERET, stall,
// branch, sequential), flags illegal fetch addresses and tracks handler state.
module pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [WIDTH-1:0] TEXT_HI    = 32'h0000_4fff,
    parameter logic [WIDTH-1:0] HANDLER_PC = 32'h0000_4180,
    parameter int               ALIGN_BITS = 2
) (
    input logic        clk,
    input logic        reset,
    pc_unit_if.slave   bus
);

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

    // Power-up values let simulation start at RESET_PC before the first reset.
    state_e           state_q    = RUN;
    logic [WIDTH-1:0] pc_q       = RESET_PC;
    logic [WIDTH-1:0] bad_pc_q   = '0;
    logic             bad_seen_q = 1'b0;
    logic             redirect_q = 1'b0;

    state_e           state_d;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] bad_pc_d;
    logic             bad_seen_d;
    logic             redirect_d;

    logic [WIDTH-1:0] pc_plus4;
    logic             pc_exp;
    logic             take_trap;
    logic             take_eret;

    assign pc_plus4  = pc_q + WIDTH'(4);
    assign pc_exp    = (pc_q < TEXT_LO) || (pc_q > TEXT_HI) || ((pc_q & ALIGN_MASK) != '0);

    // Interrupts are masked inside the handler; exceptions are always taken.
    assign take_trap = bus.exc_req || (bus.int_req && (state_q == RUN));
    assign take_eret = bus.eret && (state_q == HANDLER);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        pc_d       = pc_q;
        bad_pc_d   = bad_pc_q;
        bad_seen_d = bad_seen_q;
        redirect_d = 1'b0;

        if (take_trap) begin
            pc_d       = HANDLER_PC;
            state_d    = HANDLER;
            redirect_d = 1'b1;
        end else if (take_eret) begin
            pc_d       = bus.epc_in;
            state_d    = RUN;
            redirect_d = 1'b1;
        end else if (!bus.stall) begin
            pc_d = bus.npc_valid ? bus.npc : pc_plus4;
        end

        // Only the first illegal fetch in RUN is captured; it stays until reset.
        if (pc_exp && (state_q == RUN) && !bad_seen_q) begin
            bad_pc_d   = pc_q;
            bad_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            bad_pc_q   <= '0;
            bad_seen_q <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bad_pc_q   <= bad_pc_d;
            bad_seen_q <= bad_seen_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.pc_exp     = pc_exp;
    assign bus.bad_pc     = bad_pc_q;
    assign bus.redirect   = redirect_q;
    assign bus.in_handler = (state_q == HANDLER);

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined MIPS core's fetch stage. It holds the fetch PC and selects the next PC: sequential, branch/jump target, exception/interrupt handler entry, or ERET return. It also flags illegal fetch addresses and tracks whether the core is executing inside the handler. It replaces the fixed 32-bit stall/interrupt PC register with configurable vectors, text range and alignment.

## Interface
- WIDTH, 32, PC and address width
- RESET_PC, 32'h0000_3000, PC value after reset
- TEXT_LO, 32'h0000_3000, lowest legal fetch address (inclusive)
- TEXT_HI, 32'h0000_4fff, highest legal fetch address (inclusive)
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry vector
- ALIGN_BITS, 2, number of low PC bits that must be zero

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC (hazard stall)
- npc_valid  in  1  redirect to npc this cycle (taken branch/jump)
- npc  in  WIDTH  branch/jump target
- int_req  in  1  external interrupt request
- exc_req  in  1  precise exception from a later stage
- eret  in  1  return-from-exception
- epc_in  in  WIDTH  return address from CP0
- pc  out  WIDTH  current fetch PC
- pc_plus4  out  WIDTH  pc + 4, wraps modulo 2^WIDTH
- pc_exp  out  1  current pc illegal (combinational)
- bad_pc  out  WIDTH  first illegal PC fetched in RUN, sticky
- redirect  out  1  one-cycle pulse: PC loaded from handler/epc vector
- in_handler  out  1  state == HANDLER

## Operation
- States: RUN, HANDLER. Reset -> RUN.
- Next-PC priority, evaluated each rising edge:
  1. reset: pc=RESET_PC, state=RUN, bad_pc=0, redirect=0.
  2. exc_req, either state, or int_req in RUN: pc=HANDLER_PC, state=HANDLER, redirect=1. Ignores stall.
  3. eret in HANDLER: pc=epc_in, state=RUN, redirect=1. Ignores stall.
  4. stall: pc held.
  5. npc_valid: pc=npc.
  6. otherwise: pc=pc_plus4.
- int_req in HANDLER is masked; it is not queued. The source must hold it until it is taken.
- eret in RUN is a no-op; priorities 4-6 apply.
- exc_req and eret together in HANDLER: exc_req wins. pc=HANDLER_PC and state stays HANDLER.
- pc_exp = 1 when pc < TEXT_LO, pc > TEXT_HI, or pc[ALIGN_BITS-1:0] != 0. Compares are unsigned, full WIDTH.
- bad_pc: loaded with pc on a cycle where pc_exp=1, state=RUN and the sticky flag is clear. The flag is then set. It is cleared only by reset. Later faults do not overwrite bad_pc.
- The unit never raises an exception itself; the core routes pc_exp to the exc_req logic.

## Timing
- All state updates on the rising clk edge; no combinational path from inputs to pc.
- pc_plus4 and pc_exp are combinational from the pc register only.
- Redirect latency is 1 cycle: a request sampled at edge N gives the new pc after edge N.
- redirect is high for the cycle after a handler-entry or ERET load, then drops, unless a new load occurs.
- Reset mid-handler returns to RUN at RESET_PC on the next edge. Pending eret, exc_req and int_req are discarded.
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, pc_exp per RESET_PC (0 with defaults), bad_pc=0, redirect=0, in_handler=0.
- Initial value of pc equals RESET_PC for simulation before the first reset.

## Test plan
- Reset, then 3 free-running cycles -> pc 3000, 3004, 3008, 300c; pc_exp=0, in_handler=0.
- stall=1 at pc=3008 for 2 cycles, then npc_valid=1 with npc=3400 -> pc holds 3008 twice, then 3400.
- int_req=1 with stall=1 at pc=3010 -> next pc=4180, redirect=1 for 1 cycle, in_handler=1. int_req held 3 more cycles -> pc 4184, 4188, 418c (masked).
- In HANDLER, eret=1 with epc_in=3014 -> pc=3014, in_handler=0, redirect pulse. Then eret=1 in RUN -> pc advances to 3018.
- npc=5000, then npc=3002 -> pc_exp=1 at 5000 and bad_pc=5000. At 3002 pc_exp=1 but bad_pc stays 5000.
- Simultaneous exc_req and eret in HANDLER -> pc=4180, in_handler=1. Reset asserted while in HANDLER -> pc=3000, in_handler=0, bad_pc=0.
